// File: rtl/key_debounce_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE_REL   = 2'd0,
        PEND_PRESS = 2'd1,
        HELD       = 2'd2,
        PEND_REL   = 2'd3
    } chan_state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val == 0) begin
            return 1;
        end
        return $clog2(64'(max_val) + 64'd1);
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins in, debounced levels and event pulses out.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_multi_chan.sv
// One key channel: synchroniser, debounce counter, channel FSM and long-press timer.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned ACTIVE_LOW        = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned   DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic          REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    chan_state_e            state_q, state_d;
    logic                   key_state_q, key_state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   pressed_c, diff_c, done_c;

    // Debounce datapath and channel FSM next-state.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], key_in};
        pressed_c   = sync_q[SYNC_STAGES-1] ^ REL_LVL;
        diff_c      = (pressed_c != key_state_q);
        done_c      = diff_c && (db_cnt_q == DB_LAST);
        db_cnt_d    = (diff_c && !done_c) ? db_cnt_q + DB_W'(1) : '0;
        key_state_d = key_state_q ^ done_c;
        press_d     = done_c & ~key_state_q;
        release_d   = done_c & key_state_q;
        state_d     = state_q;
        unique case (state_q)
            IDLE_REL: begin
                if (done_c)      state_d = HELD;
                else if (diff_c) state_d = PEND_PRESS;
            end
            PEND_PRESS: begin
                if (!diff_c)     state_d = IDLE_REL;
                else if (done_c) state_d = HELD;
            end
            HELD: begin
                if (done_c)      state_d = IDLE_REL;
                else if (diff_c) state_d = PEND_REL;
            end
            PEND_REL: begin
                if (!diff_c)     state_d = HELD;
                else if (done_c) state_d = IDLE_REL;
            end
            default: state_d = IDLE_REL;
        endcase
    end

    // Synchroniser resets to the released pin level so reset release is silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{REL_LVL}};
            db_cnt_q    <= '0;
            state_q     <= IDLE_REL;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

    if (LONG_PRESS_CYCLES > 0) begin : g_long
        localparam int unsigned     LP_W    = cnt_width(LONG_PRESS_CYCLES);
        localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES);

        logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
        logic            fired_q, fired_d;
        logic            long_q, long_d;

        // Counts while pressed and not yet fired, including during a pending release.
        always_comb begin
            lp_cnt_d = lp_cnt_q;
            fired_d  = fired_q;
            long_d   = 1'b0;
            if (press_d) begin
                lp_cnt_d = '0;
            end else if (key_state_q && !fired_q) begin
                lp_cnt_d = lp_cnt_q + LP_W'(1);
                if (lp_cnt_d == LP_LAST) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end
            if (release_d) begin
                fired_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lp_cnt_q <= '0;
                fired_q  <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                lp_cnt_q <= lp_cnt_d;
                fired_q  <= fired_d;
                long_q   <= long_d;
            end
        end

        assign key_long = long_q;
    end else begin : g_no_long
        assign key_long = 1'b0;
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: NUM_KEYS independent channels side by side.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned ACTIVE_LOW        = 1
) (
    input  logic                 system_clk,
    input  logic                 system_rst,
    key_debounce_multi_if.slave  kif
);

    logic [NUM_KEYS-1:0] state_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] release_w;
    logic [NUM_KEYS-1:0] long_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .SYNC_STAGES       (SYNC_STAGES),
            .ACTIVE_LOW        (ACTIVE_LOW)
        ) u_chan (
            .clk         (system_clk),
            .rst         (system_rst),
            .key_in      (kif.key_in[i]),
            .key_state   (state_w[i]),
            .key_press   (press_w[i]),
            .key_release (release_w[i]),
            .key_long    (long_w[i])
        );
    end

    assign kif.key_state   = state_w;
    assign kif.key_press   = press_w;
    assign kif.key_release = release_w;
    assign kif.key_long    = long_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: 2 keys, 8-cycle debounce, 20-cycle long press.
module tb_key_debounce_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    key_debounce_multi_if #(.NUM_KEYS(2)) kif ();

    key_debounce_multi #(
        .NUM_KEYS          (2),
        .DEBOUNCE_CYCLES   (8),
        .LONG_PRESS_CYCLES (20),
        .SYNC_STAGES       (2),
        .ACTIVE_LOW        (1)
    ) dut (
        .system_clk (clk),
        .system_rst (rst),
        .kif        (kif)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] all_out();
        return {kif.key_long, kif.key_release, kif.key_press, kif.key_state};
    endfunction

    initial begin
        kif.key_in = 2'b11;

        // Reset held with keys released, then 50 quiet cycles.
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 8'h00);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("quiet_after_reset", all_out(), 8'h00);
        end

        // Clean press on key 0: pulse on edge 10 counting the sampling edge as 1.
        kif.key_in = 2'b10;
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            chk("press_pulse", 8'(kif.key_press), (e == 10) ? 8'h01 : 8'h00);
            chk("press_state", 8'(kif.key_state), (e >= 10) ? 8'h01 : 8'h00);
            if (e > 10) chk("long_pulse", 8'(kif.key_long), (e == 30) ? 8'h01 : 8'h00);
        end

        // Release key 0 after a long hold; no further long pulse.
        kif.key_in = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            chk("release_pulse", 8'(kif.key_release), (e == 10) ? 8'h01 : 8'h00);
            chk("release_state", 8'(kif.key_state), (e >= 10) ? 8'h00 : 8'h01);
            chk("no_long_on_release", 8'(kif.key_long), 8'h00);
        end

        // Glitches of 7 low cycles never get accepted.
        for (int r = 0; r < 5; r++) begin
            kif.key_in = 2'b10;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                chk("glitch_low", all_out(), 8'h00);
            end
            kif.key_in = 2'b11;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("glitch_high", all_out(), 8'h00);
            end
        end
        repeat (12) begin
            @(negedge clk);
            chk("glitch_settle", all_out(), 8'h00);
        end

        // Short press: release pin 5 cycles after key_press, no long pulse.
        kif.key_in = 2'b10;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            chk("short_press", 8'(kif.key_press), (e == 10) ? 8'h01 : 8'h00);
            chk("short_release", 8'(kif.key_release), (e == 25) ? 8'h01 : 8'h00);
            chk("short_no_long", 8'(kif.key_long), 8'h00);
            if (e == 15) kif.key_in = 2'b11;
        end

        // Both keys on the same edge, then release key 1 only.
        kif.key_in = 2'b00;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            chk("both_press", 8'(kif.key_press), (e == 10) ? 8'h03 : 8'h00);
        end
        chk("both_state", 8'(kif.key_state), 8'h03);
        kif.key_in = 2'b10;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            chk("key1_release", 8'(kif.key_release), (e == 10) ? 8'h02 : 8'h00);
            chk("key1_state", 8'(kif.key_state), (e >= 10) ? 8'h01 : 8'h03);
        end

        // Asynchronous reset mid-cycle while key 0 is held.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", all_out(), 8'h00);
        kif.key_in = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("after_async_reset", all_out(), 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel key debouncer, successor to the single-key 20 ms filter.
- Each channel provides:
  - synchronisation of the raw pin;
  - a configurable debounce window;
  - a debounced level;
  - single-cycle press and release pulses;
  - an optional long-press pulse.
- Sits between the board push-buttons and the control FSMs (e.g. the SPI flash read/erase triggers).

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must differ from the debounced state before the state changes (20 ms at 50 MHz). Must be ≥1.
- LONG_PRESS_CYCLES, 50000000, cycles after an accepted press before key_long fires. 0 disables long-press.
- SYNC_STAGES, 2, synchroniser flops per channel. Must be ≥2.
- ACTIVE_LOW, 1, 1 = key pressed when pin is 0; 0 = pressed when pin is 1.

Ports:
- system_clk  in  1  single system clock; all logic on its rising edge.
- system_rst  in  1  reset, asynchronous, active-high.
- key_in  in  NUM_KEYS  raw asynchronous key pins.
- key_state  out  NUM_KEYS  debounced level; 1 = pressed, independent of ACTIVE_LOW.
- key_press  out  NUM_KEYS  one-cycle pulse when a press is accepted.
- key_release  out  NUM_KEYS  one-cycle pulse when a release is accepted.
- key_long  out  NUM_KEYS  one-cycle pulse, at most once per press, LONG_PRESS_CYCLES after key_press.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0;
  - synchroniser flops load the released pin level (1 if ACTIVE_LOW, else 0), so there is no spurious press after reset;
  - all counters 0;
  - long-fired flags 0.
- Synchroniser: key_in[i] passes through SYNC_STAGES flops, then is normalised to pressed = 1 (inverted when ACTIVE_LOW).
- Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES+1):
  - if sync == key_state: counter cleared to 0;
  - else: counter increments;
  - on the cycle counter == DEBOUNCE_CYCLES-1 with sync still differing: key_state toggles at that edge, counter clears, and key_press or key_release is asserted in the same cycle key_state changes, for exactly one cycle.
- Glitch rejection: any return to the current state before the count completes clears the counter. Bounces shorter than DEBOUNCE_CYCLES never change key_state.
- Latency: a clean level change appears on key_state/pulse exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new pin level.
- Long-press counter, per channel, width $clog2(LONG_PRESS_CYCLES+1):
  - cleared on key_press;
  - increments while key_state == 1 and long-fired == 0;
  - when it reaches LONG_PRESS_CYCLES: key_long pulses one cycle, long-fired is set, counter holds.
  - long-fired clears on key_release.
  - A release before the count completes produces no key_long.
  - Never counts while released.
  - LONG_PRESS_CYCLES = 0: key_long tied 0, counter logic removed.
- Per-channel state machine:
  - IDLE_REL: released, stable.
  - PEND_PRESS: counting toward press.
  - HELD: pressed, long counting or long already fired.
  - PEND_REL: counting toward release.
  - Transitions:
    - IDLE_REL to PEND_PRESS on sync = 1.
    - PEND_PRESS to IDLE_REL on sync = 0.
    - PEND_PRESS to HELD on count done.
    - Symmetric for release: HELD to PEND_REL on sync = 0; PEND_REL to HELD on sync = 1; PEND_REL to IDLE_REL on count done.
  - The long counter keeps running in PEND_REL. If it completes there, key_long may fire; key_state is still 1.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- key_press and key_release are never high together on a channel.
- Reset mid-count or mid-hold: everything returns to IDLE_REL immediately. No pulses on reset assert or release.

Decomposition:
- Shared package key_pkg:
  - localparam function for counter width (clog2-based);
  - channel-state enum {IDLE_REL, PEND_PRESS, HELD, PEND_REL}.
- Sub-module key_debounce_chan: one channel (synchroniser, debounce counter, FSM, long-press), instantiated NUM_KEYS times via generate.
- Top level: only the generate loop and output concatenation.

Test Plan (bench parameters NUM_KEYS=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=20, SYNC_STAGES=2, ACTIVE_LOW=1):
- Reset with key_in=2'b11 held, then release reset -> key_state=0, no pulses for 50 cycles. Assert system_rst mid-cycle -> outputs 0 immediately (async).
- key_in[0] 1→0 clean, held -> key_press[0] high exactly at edge 10 after the sampling edge, one cycle; key_state[0]=1 from then on. Channel 1 stays quiet.
- key_in[0] low pulses of 7 cycles repeated 5 times, separated by 3 high cycles -> no key_press, key_state[0] stays 0.
- Hold key 0 for 40 cycles after key_press -> key_long[0] one pulse exactly 20 cycles after key_press, no second pulse. Release -> key_release[0] 10 edges after the pin rises.
- Press and release key 0 within 15 cycles of key_press -> key_release fires, key_long never fires.
- Both keys pressed on the same edge -> key_press=2'b11 in one cycle. Release key 1 only -> key_release=2'b10, key_state=2'b01.
